// File: rtl/hp_slave_memory_if.sv
// hp_slave_memory_if
//   AXI3 channel bundle between one master and the hp_slave_memory slave.
//   Parameter ID_WIDTH sets the width of every ID field.
//   Channels: AW (write address), W (write data), B (write response),
//             AR (read address), R (read data).
//   Modports: master drives valids/readys of the request side,
//             slave drives readys and the response channels.
interface hp_slave_memory_if #(
  parameter int ID_WIDTH = 6
);
  logic                awvalid;
  logic                awready;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [ID_WIDTH-1:0] awid;

  logic                wvalid;
  logic                wready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic [ID_WIDTH-1:0] wid;

  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic [ID_WIDTH-1:0] bid;

  logic                arvalid;
  logic                arready;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_WIDTH-1:0] arid;

  logic                rvalid;
  logic                rready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic [ID_WIDTH-1:0] rid;
  logic                rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wid,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arid,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast, wid,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );
endinterface

// File: rtl/hp_slave_memory.sv
// hp_slave_memory
//   AXI3 slave backed by a 2^DEPTH_LOG2 x 32-bit word memory. Serves one
//   transaction at a time (IDLE -> WDATA -> WRESP or IDLE -> RDATA).
//   Word index is addr[DEPTH_LOG2+1:2]; upper address bits alias.
//   Only 32-bit beats (size 010) with FIXED or INCR bursts are legal; an
//   illegal transaction is fully consumed but writes nothing / reads zero,
//   and is answered with SLVERR.
// Ports:
//   clock  - single clock, rising edge
//   reset  - synchronous, active-low
//   bus    - AXI3 slave modport (AW, W, B, AR, R channels)
module hp_slave_memory #(
  parameter int DEPTH_LOG2 = 6,
  parameter int ID_WIDTH   = 6
) (
  input logic               clock,
  input logic               reset,
  hp_slave_memory_if.slave  bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WRESP,
    RDATA
  } state_t;

  state_t                state_q;
  logic [31:0]           mem_q [WORDS];

  logic [DEPTH_LOG2-1:0] index_q;
  logic [3:0]            len_q;
  logic [1:0]            burst_q;
  logic                  legal_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [4:0]            beatCount_q;
  logic                  err_q;

  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic                  rlast_q;

  logic [DEPTH_LOG2-1:0] index_d;
  logic [4:0]            beatCount_d;
  logic [DEPTH_LOG2-1:0] awIndex;
  logic [DEPTH_LOG2-1:0] arIndex;
  logic                  awLegal;
  logic                  arLegal;
  logic                  wHandshake;
  logic                  memWrite;
  logic                  wBeatErr;
  logic [31:0]           arWord;
  logic [31:0]           nextWord;
  logic                  unusedAddrBits;

  assign bus.awready = awready_q;
  assign bus.arready = (state_q == IDLE) && !bus.awvalid;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.rlast   = rlast_q;

  assign awIndex = bus.awaddr[DEPTH_LOG2+1:2];
  assign arIndex = bus.araddr[DEPTH_LOG2+1:2];
  assign unusedAddrBits = ^{bus.awaddr[31:DEPTH_LOG2+2], bus.awaddr[1:0],
                            bus.araddr[31:DEPTH_LOG2+2], bus.araddr[1:0]};

  assign awLegal = (bus.awsize == 3'b010) && !bus.awburst[1];
  assign arLegal = (bus.arsize == 3'b010) && !bus.arburst[1];

  // FIXED keeps the word, INCR wraps naturally at the top of memory.
  assign index_d = (burst_q == 2'b00) ? index_q : index_q + 1'b1;

  // Saturate so an endless stream of beats can never wrap back into range.
  assign beatCount_d = (beatCount_q == 5'h1f) ? beatCount_q : beatCount_q + 5'd1;

  assign wHandshake = (state_q == WDATA) && wready_q && bus.wvalid;
  assign memWrite   = wHandshake && legal_q && reset &&
                      (beatCount_q <= {1'b0, len_q});

  // A beat is in error on an ID mismatch, on wlast arriving early or late,
  // or on any beat beyond len+1.
  assign wBeatErr = (bus.wid != id_q) ||
                    (bus.wlast && (beatCount_q != {1'b0, len_q})) ||
                    (!bus.wlast && (beatCount_q >= {1'b0, len_q}));

  assign arWord   = arLegal ? mem_q[arIndex] : 32'h0;
  assign nextWord = legal_q ? mem_q[index_d] : 32'h0;

  // Byte-lane write port; the array has no reset so contents survive reset.
  always_ff @(posedge clock) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[index_q][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with all channel outputs registered. Read data for the
  // next beat is fetched on the current handshake so rdata is always the
  // word at the current index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      len_q       <= 4'd0;
      burst_q     <= 2'b00;
      legal_q     <= 1'b0;
      id_q        <= '0;
      beatCount_q <= 5'd0;
      err_q       <= 1'b0;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      bid_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      rresp_q     <= 2'b00;
      rid_q       <= '0;
      rlast_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.awvalid) begin
            index_q     <= awIndex;
            len_q       <= bus.awlen;
            burst_q     <= bus.awburst;
            legal_q     <= awLegal;
            id_q        <= bus.awid;
            beatCount_q <= 5'd0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b1;
            state_q     <= WDATA;
          end else if (bus.arvalid) begin
            index_q     <= arIndex;
            len_q       <= bus.arlen;
            burst_q     <= bus.arburst;
            legal_q     <= arLegal;
            id_q        <= bus.arid;
            beatCount_q <= 5'd0;
            awready_q   <= 1'b0;
            rvalid_q    <= 1'b1;
            rdata_q     <= arWord;
            rresp_q     <= arLegal ? 2'b00 : 2'b10;
            rid_q       <= bus.arid;
            rlast_q     <= (bus.arlen == 4'd0);
            state_q     <= RDATA;
          end
        end
        WDATA: begin
          if (wHandshake) begin
            index_q     <= index_d;
            beatCount_q <= beatCount_d;
            if (wBeatErr) begin
              err_q <= 1'b1;
            end
            if (bus.wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (!legal_q || err_q || wBeatErr) ? 2'b10 : 2'b00;
              bid_q    <= id_q;
              state_q  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        RDATA: begin
          if (bus.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              awready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              index_q     <= index_d;
              beatCount_q <= beatCount_d;
              rdata_q     <= nextWord;
              rlast_q     <= (beatCount_d == {1'b0, len_q});
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_slave_memory.sv
// tb_hp_slave_memory
//   Directed self-checking bench for hp_slave_memory (DEPTH_LOG2=6,
//   ID_WIDTH=6). A table of single-beat write/read-back records covers the
//   basic data path, strobes, aliasing and illegal requests; hand-written
//   sequences cover bursts with wrap, early wlast, AW/AR tie, read stall,
//   illegal read and reset in the middle of a write.
module tb_hp_slave_memory;

  localparam int IDW    = 6;
  localparam int BUDGET = 50;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  hp_slave_memory_if #(.ID_WIDTH(IDW)) bus ();

  hp_slave_memory #(
    .DEPTH_LOG2(6),
    .ID_WIDTH  (IDW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0]    addr;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic [IDW-1:0] id;
    logic           widBad;
    logic [31:0]    data;
    logic [3:0]     strb;
    logic [1:0]     expBresp;
    logic [31:0]    readAddr;
    logic [31:0]    expRdata;
  } vec_t;

  vec_t vecs[10];

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitNeg();
    @(negedge clock);
    #1;
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout expected handshake", name);
  endtask

  // Full write transaction: AW, nBeats W beats (wlast on the final one), B.
  // bWait counts cycles bvalid took to appear after the final W handshake.
  task automatic doWrite(input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [IDW-1:0] id, input logic [IDW-1:0] wid,
                         input int nBeats, input logic [127:0] data,
                         input logic [3:0] strb, output logic [1:0] resp,
                         output logic [IDW-1:0] bidOut, output int bWait);
    int n;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = size;
    bus.awburst = burst;
    bus.awid    = id;
    #1;
    n = 0;
    while (!bus.awready && n < BUDGET) begin waitNeg(); n++; end
    if (n >= BUDGET) timeoutFail("awHandshake");
    @(posedge clock); #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b < nBeats; b++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = data[32*b +: 32];
      bus.wstrb  = strb;
      bus.wlast  = (b == nBeats - 1);
      bus.wid    = wid;
      #1;
      n = 0;
      while (!bus.wready && n < BUDGET) begin waitNeg(); n++; end
      if (n >= BUDGET) timeoutFail("wHandshake");
      @(posedge clock); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    #1;
    bWait = 0;
    while (!bus.bvalid && bWait < BUDGET) begin waitNeg(); bWait++; end
    if (bWait >= BUDGET) timeoutFail("bHandshake");
    resp   = bus.bresp;
    bidOut = bus.bid;
    @(posedge clock); #1;
    bus.bready = 1'b0;
  endtask

  // Full read transaction; beat b data lands in dataOut[32*b +: 32] and its
  // rlast in lastOut[b]. resp/id come from the first beat.
  task automatic doRead(input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst,
                        input logic [IDW-1:0] id, output logic [127:0] dataOut,
                        output logic [3:0] lastOut, output logic [1:0] respOut,
                        output logic [IDW-1:0] idOut);
    int n;
    dataOut = '0;
    lastOut = '0;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arburst = burst;
    bus.arid    = id;
    #1;
    n = 0;
    while (!bus.arready && n < BUDGET) begin waitNeg(); n++; end
    if (n >= BUDGET) timeoutFail("arHandshake");
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      #1;
      n = 0;
      while (!bus.rvalid && n < BUDGET) begin waitNeg(); n++; end
      if (n >= BUDGET) timeoutFail("rHandshake");
      dataOut[32*b +: 32] = bus.rdata;
      lastOut[b] = bus.rlast;
      if (b == 0) begin
        respOut = bus.rresp;
        idOut   = bus.rid;
      end
      @(posedge clock); #1;
    end
    bus.rready = 1'b0;
  endtask

  // One table record: single-beat write, then single-beat read-back.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [1:0]     resp;
    logic [IDW-1:0] bidOut;
    int             bWait;
    logic [127:0]   rd;
    logic [3:0]     lastv;
    logic [1:0]     rresp;
    logic [IDW-1:0] ridOut;
    logic [IDW-1:0] wid;
    string          tag;
    tag = $sformatf("vec%0d", idx);
    wid = v.widBad ? ~v.id : v.id;
    doWrite(v.addr, 4'd0, v.size, v.burst, v.id, wid, 1, {96'h0, v.data},
            v.strb, resp, bidOut, bWait);
    checkOutput({tag, "_bresp"}, 32'(resp), 32'(v.expBresp));
    checkOutput({tag, "_bid"}, 32'(bidOut), 32'(v.id));
    checkOutput({tag, "_bLatency"}, 32'(bWait), 32'd0);
    doRead(v.readAddr, 4'd0, 3'b010, 2'b01, v.id, rd, lastv, rresp, ridOut);
    checkOutput({tag, "_rdata"}, rd[31:0], v.expRdata);
    checkOutput({tag, "_rresp"}, 32'(rresp), 32'd0);
    checkOutput({tag, "_rlast"}, 32'(lastv[0]), 32'd1);
    checkOutput({tag, "_rid"}, 32'(ridOut), 32'(v.id));
  endtask

  initial begin
    logic [1:0]     resp;
    logic [IDW-1:0] bidOut;
    int             bWait;
    logic [127:0]   rd;
    logic [3:0]     lastv;
    logic [1:0]     rresp;
    logic [IDW-1:0] ridOut;
    logic [31:0]    held;
    logic           heldLast;
    int             n;

    checks   = 0;
    failures = 0;

    //         addr          size    burst  id     bad   data           strb     bresp  readAddr      expRdata
    vecs[0] = '{32'h00000100, 3'b010, 2'b00, 6'd5,  1'b0, 32'hDEADBEEF, 4'b1111, 2'b00, 32'h00000100, 32'hDEADBEEF};
    vecs[1] = '{32'h00000010, 3'b010, 2'b01, 6'd1,  1'b0, 32'hFFFFFFFF, 4'b1111, 2'b00, 32'h00000010, 32'hFFFFFFFF};
    vecs[2] = '{32'h00000010, 3'b010, 2'b01, 6'd2,  1'b0, 32'h00000000, 4'b0101, 2'b00, 32'h00000010, 32'hFF00FF00};
    vecs[3] = '{32'h00001010, 3'b010, 2'b01, 6'd3,  1'b0, 32'h12345678, 4'b1111, 2'b00, 32'h00000010, 32'h12345678};
    vecs[4] = '{32'h00000020, 3'b010, 2'b00, 6'd4,  1'b0, 32'h0BADF00D, 4'b1111, 2'b00, 32'h00000020, 32'h0BADF00D};
    vecs[5] = '{32'h00000020, 3'b001, 2'b00, 6'd6,  1'b0, 32'h11111111, 4'b1111, 2'b10, 32'h00000020, 32'h0BADF00D};
    vecs[6] = '{32'h00000020, 3'b010, 2'b10, 6'd7,  1'b0, 32'h22222222, 4'b1111, 2'b10, 32'h00000020, 32'h0BADF00D};
    vecs[7] = '{32'h00000024, 3'b010, 2'b01, 6'd8,  1'b1, 32'h33333333, 4'b1111, 2'b10, 32'h00000024, 32'h33333333};
    vecs[8] = '{32'h00000020, 3'b010, 2'b01, 6'd9,  1'b0, 32'hFFFFFFFF, 4'b0000, 2'b00, 32'h00000020, 32'h0BADF00D};
    vecs[9] = '{32'h00000020, 3'b010, 2'b01, 6'd10, 1'b0, 32'hABCCCCCC, 4'b1000, 2'b00, 32'h00000020, 32'hABADF00D};

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
    bus.awburst = '0;   bus.awid = '0;
    bus.wvalid = 1'b0;  bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wid = '0;
    bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0;   bus.arid = '0;
    bus.rready = 1'b0;

    // Reset and check the idle output state.
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    waitNeg();
    checkOutput("rst_awready", 32'(bus.awready), 32'd1);
    checkOutput("rst_arready", 32'(bus.arready), 32'd1);
    checkOutput("rst_wready",  32'(bus.wready),  32'd0);
    checkOutput("rst_bvalid",  32'(bus.bvalid),  32'd0);
    checkOutput("rst_rvalid",  32'(bus.rvalid),  32'd0);
    checkOutput("rst_bresp",   32'(bus.bresp),   32'd0);
    checkOutput("rst_rresp",   32'(bus.rresp),   32'd0);
    checkOutput("rst_rlast",   32'(bus.rlast),   32'd0);
    checkOutput("rst_bid",     32'(bus.bid),     32'd0);
    checkOutput("rst_rid",     32'(bus.rid),     32'd0);
    checkOutput("rst_rdata",   bus.rdata,        32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], i);
    end

    // INCR burst of four that wraps from word 63 to word 0.
    doWrite(32'h000000F8, 4'd3, 3'b010, 2'b01, 6'd3, 6'd3, 4,
            {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, resp, bidOut, bWait);
    checkOutput("incrW_bresp", 32'(resp), 32'd0);
    checkOutput("incrW_bid", 32'(bidOut), 32'd3);
    doRead(32'h000000F8, 4'd3, 3'b010, 2'b01, 6'd12, rd, lastv, rresp, ridOut);
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("incrR_beat%0d", b), rd[32*b +: 32], 32'(b + 1));
    end
    checkOutput("incrR_rlast", 32'(lastv), 32'b1000);
    checkOutput("incrR_rid", 32'(ridOut), 32'd12);
    doRead(32'h00000000, 4'd0, 3'b010, 2'b00, 6'd1, rd, lastv, rresp, ridOut);
    checkOutput("wrapWord0", rd[31:0], 32'd3);
    doRead(32'h00000004, 4'd0, 3'b010, 2'b00, 6'd1, rd, lastv, rresp, ridOut);
    checkOutput("wrapWord1", rd[31:0], 32'd4);

    // wlast on the first beat of a three-beat burst.
    doWrite(32'h00000040, 4'd2, 3'b010, 2'b01, 6'd11, 6'd11, 1,
            {96'h0, 32'h00000066}, 4'b1111, resp, bidOut, bWait);
    checkOutput("earlyLast_bresp", 32'(resp), 32'd2);
    checkOutput("earlyLast_bid", 32'(bidOut), 32'd11);

    // AW and AR together: write wins, read waits for the B handshake, then
    // the read beat is held with rready low.
    bus.awvalid = 1'b1; bus.awaddr = 32'h80; bus.awlen = 4'd0;
    bus.awsize = 3'b010; bus.awburst = 2'b00; bus.awid = 6'd9;
    bus.arvalid = 1'b1; bus.araddr = 32'h80; bus.arlen = 4'd0;
    bus.arsize = 3'b010; bus.arburst = 2'b00; bus.arid = 6'd7;
    #1;
    checkOutput("tie_awready", 32'(bus.awready), 32'd1);
    checkOutput("tie_arready", 32'(bus.arready), 32'd0);
    @(posedge clock); #1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'b1111;
    bus.wlast = 1'b1; bus.wid = 6'd9;
    #1;
    checkOutput("tie_arreadyInW", 32'(bus.arready), 32'd0);
    n = 0;
    while (!bus.wready && n < BUDGET) begin waitNeg(); n++; end
    if (n >= BUDGET) timeoutFail("tie_w");
    @(posedge clock); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    #1;
    n = 0;
    while (!bus.bvalid && n < BUDGET) begin waitNeg(); n++; end
    if (n >= BUDGET) timeoutFail("tie_b");
    checkOutput("tie_arreadyInB", 32'(bus.arready), 32'd0);
    checkOutput("tie_bresp", 32'(bus.bresp), 32'd0);
    checkOutput("tie_bid", 32'(bus.bid), 32'd9);
    @(posedge clock); #1;
    bus.bready = 1'b0;
    checkOutput("tie_arreadyAfterB", 32'(bus.arready), 32'd1);
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
    #1;
    n = 0;
    while (!bus.rvalid && n < BUDGET) begin waitNeg(); n++; end
    if (n >= BUDGET) timeoutFail("tie_r");
    held = bus.rdata;
    heldLast = bus.rlast;
    checkOutput("tie_rdata", held, 32'hCAFEF00D);
    checkOutput("tie_rid", 32'(bus.rid), 32'd7);
    for (int s = 0; s < 3; s++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("stall%0d_rvalid", s), 32'(bus.rvalid), 32'd1);
      checkOutput($sformatf("stall%0d_rdata", s), bus.rdata, 32'hCAFEF00D);
      checkOutput($sformatf("stall%0d_rlast", s), 32'(bus.rlast), 32'd1);
    end
    bus.rready = 1'b1;
    @(posedge clock); #1;
    bus.rready = 1'b0;
    checkOutput("tie_rvalidDone", 32'(bus.rvalid), 32'd0);
    checkOutput("tie_heldLast", 32'(heldLast), 32'd1);

    // Illegal read returns zero data with SLVERR.
    doRead(32'h00000080, 4'd0, 3'b010, 2'b10, 6'd2, rd, lastv, rresp, ridOut);
    checkOutput("illegalR_rdata", rd[31:0], 32'd0);
    checkOutput("illegalR_rresp", 32'(rresp), 32'd2);
    checkOutput("illegalR_rlast", 32'(lastv[0]), 32'd1);

    // Reset pulse while in WDATA, coinciding with a W beat.
    doWrite(32'h00000060, 4'd0, 3'b010, 2'b00, 6'd13, 6'd13, 1,
            {96'h0, 32'h13572468}, 4'b1111, resp, bidOut, bWait);
    checkOutput("preRst_bresp", 32'(resp), 32'd0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h60; bus.awlen = 4'd1;
    bus.awsize = 3'b010; bus.awburst = 2'b01; bus.awid = 6'd14;
    @(posedge clock); #1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hBAD0BAD0; bus.wstrb = 4'b1111;
    bus.wlast = 1'b0; bus.wid = 6'd14;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    bus.wvalid = 1'b0;
    checkOutput("midRst_awready", 32'(bus.awready), 32'd1);
    checkOutput("midRst_arready", 32'(bus.arready), 32'd1);
    checkOutput("midRst_wready",  32'(bus.wready),  32'd0);
    checkOutput("midRst_bvalid",  32'(bus.bvalid),  32'd0);
    checkOutput("midRst_rvalid",  32'(bus.rvalid),  32'd0);
    checkOutput("midRst_bid",     32'(bus.bid),     32'd0);
    repeat (3) begin
      waitNeg();
      checkOutput("midRst_noB", 32'(bus.bvalid), 32'd0);
    end
    doRead(32'h00000060, 4'd0, 3'b010, 2'b00, 6'd1, rd, lastv, rresp, ridOut);
    checkOutput("midRst_retained", rd[31:0], 32'h13572468);
    doRead(32'h00000100, 4'd0, 3'b010, 2'b00, 6'd5, rd, lastv, rresp, ridOut);
    checkOutput("midRst_retainedWord0", rd[31:0], 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
